// File: rtl/led_pwm_fader_if.sv
// Control/status bundle between the PIO-side driver and the LED PWM fader.
// The master drives the target level and enable; the fader reports its PWM state back.
interface led_pwm_fader_if;
  localparam int unsigned LVL_W = 4;

  logic [LVL_W-1:0] level_in;
  logic             enable;
  logic             pwm_out;
  logic [LVL_W-1:0] level_cur;
  logic             busy;
  logic             period_start;

  modport master (
    output level_in,
    output enable,
    input  pwm_out,
    input  level_cur,
    input  busy,
    input  period_start
  );

  modport slave (
    input  level_in,
    input  enable,
    output pwm_out,
    output level_cur,
    output busy,
    output period_start
  );
endinterface

// File: rtl/led_pwm_fader.sv
// 15-slot LED PWM whose duty tracks a 4-bit level; duty only changes on period boundaries.
// Optional feature macro LED_PWM_FADER_FADE_EN: ramp the level one step per FADE_PERIODS periods.
module led_pwm_fader #(
  parameter int unsigned PRESCALE     = 50,
  parameter int unsigned FADE_PERIODS = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  led_pwm_fader_if.slave bus
);

  localparam int unsigned PRE_W  = $clog2(PRESCALE);
  localparam int unsigned SLOTS  = 15;
  localparam int unsigned SLOT_W = 4;
  localparam int unsigned LVL_W  = 4;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

  // Reject out-of-range configurations at elaboration time.
  if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
    $error("led_pwm_fader: PRESCALE must be in 2..65535");
  end
  if (FADE_PERIODS < 1 || FADE_PERIODS > 255) begin : g_bad_fade
    $error("led_pwm_fader: FADE_PERIODS must be in 1..255");
  end

  logic [PRE_W-1:0]  pre_cnt;
  logic [SLOT_W-1:0] slot;
  logic [LVL_W-1:0]  level_cur;
  logic [LVL_W-1:0]  level_nxt;
  logic              pwm_out;
  logic              period_start;
  logic              tick;
  logic              boundary;

  always_comb begin
    tick     = bus.enable && (pre_cnt == PRE_LAST);
    boundary = tick && (slot == SLOT_LAST);
  end

  // Prescaler: free-running while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (!bus.enable || pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Slot counter: 15 slots per PWM period, restarts at 0 after disable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot <= '0;
    end else if (!bus.enable) begin
      slot <= '0;
    end else if (tick) begin
      slot <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
    end
  end

`ifdef LED_PWM_FADER_FADE_EN
  localparam int unsigned FADE_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_PERIODS - 1);

  logic [FADE_W-1:0] fade_cnt;

  // Counts boundaries between fade steps; cleared whenever the PWM is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fade_cnt <= '0;
    end else if (!bus.enable) begin
      fade_cnt <= '0;
    end else if (boundary) begin
      fade_cnt <= (fade_cnt == FADE_LAST) ? '0 : fade_cnt + FADE_W'(1);
    end
  end

  // One step toward the target; a reversed target just flips the direction.
  always_comb begin
    level_nxt = level_cur;
    if (boundary && fade_cnt == FADE_LAST) begin
      if (level_cur < bus.level_in) begin
        level_nxt = level_cur + LVL_W'(1);
      end else if (level_cur > bus.level_in) begin
        level_nxt = level_cur - LVL_W'(1);
      end
    end
  end
`else
  // Jump straight to whatever target is present at the boundary tick.
  always_comb begin
    level_nxt = level_cur;
    if (boundary) begin
      level_nxt = bus.level_in;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_cur <= '0;
    end else begin
      level_cur <= level_nxt;
    end
  end

  // Output stage: duty compare against the level in force and the boundary pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= bus.enable && (slot < level_cur);
      period_start <= boundary;
    end
  end

  assign bus.pwm_out      = pwm_out;
  assign bus.level_cur    = level_cur;
  assign bus.period_start = period_start;
  assign bus.busy         = (level_cur != bus.level_in);

endmodule

// File: tb/tb_led_pwm_fader.sv
// Randomized + directed bench for led_pwm_fader against an elapsed-cycle reference model.
module tb_led_pwm_fader;
  localparam int unsigned P      = 2;
  localparam int unsigned FP     = 2;
  localparam int unsigned PERIOD = 15 * P;
  localparam int unsigned RAMP   = 15 * FP * PERIOD + 60;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  led_pwm_fader_if bus ();

  led_pwm_fader #(.PRESCALE(P), .FADE_PERIODS(FP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: cycles run since enable, and the values outputs should hold.
  int m_run;
  int m_bnd;
  int m_level;
  int m_pwm;
  int m_ps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_bnd = 0; m_level = 0; m_pwm = 0; m_ps = 0;
  endtask

  function automatic int m_slot();
    return (m_run / P) % 15;
  endfunction

  // Advance the model by one clk using the inputs presently applied.
  task automatic model_step();
    int  s;
    bit  bnd;
    if (!bus.enable) begin
      m_run = 0; m_bnd = 0; m_pwm = 0; m_ps = 0;
    end else begin
      s     = m_slot();
      bnd   = (m_run % PERIOD) == PERIOD - 1;
      m_pwm = (s < m_level) ? 1 : 0;
      m_ps  = bnd ? 1 : 0;
      if (bnd) begin
`ifdef LED_PWM_FADER_FADE_EN
        if (m_bnd % FP == FP - 1) begin
          if (m_level < int'(bus.level_in)) m_level++;
          else if (m_level > int'(bus.level_in)) m_level--;
        end
`else
        m_level = int'(bus.level_in);
`endif
        m_bnd++;
      end
      m_run++;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("pwm_out", 32'(bus.pwm_out), 32'(m_pwm));
    check("level_cur", 32'(bus.level_cur), 32'(m_level));
    check("period_start", 32'(bus.period_start), 32'(m_ps));
    check("busy", 32'(bus.busy), (m_level != int'(bus.level_in)) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_level(input int target);
    int n;
    n = 0;
    while (int'(bus.level_cur) != target && n < int'(RAMP)) begin
      cycle();
      n++;
    end
    check("wait_level", 32'(bus.level_cur), 32'(target));
  endtask

  task automatic wait_slot(input int target);
    int n;
    n = 0;
    while (m_slot() != target && n < int'(PERIOD) + 2) begin
      cycle();
      n++;
    end
    check("wait_slot", 32'(m_slot()), 32'(target));
  endtask

  initial begin
    int cnt;
    int ps_cnt;
    int lvl;
    int prev;
    int busy_fall;
    int chg[$];
    checks = 0;
    failures = 0;
    model_reset();

    // Reset values with a nonzero target pending.
    reset_n = 1'b0;
    bus.enable = 1'b0;
    bus.level_in = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", 32'(bus.pwm_out), 32'd0);
    check("rst_level", 32'(bus.level_cur), 32'd0);
    check("rst_ps", 32'(bus.period_start), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Steady duty 5 and period_start cadence.
    bus.enable = 1'b1;
    cnt = 0;
    ps_cnt = 0;
    for (int k = 0; k < 90; k++) begin
      cycle();
      if (k >= 30 && bus.pwm_out) cnt++;
      if (bus.period_start) ps_cnt++;
    end
    check("ps_per_30clk", 32'(ps_cnt), 32'd3);
`ifndef LED_PWM_FADER_FADE_EN
    check("duty5_high_clks", 32'(cnt), 32'd20);
`endif

    // Extremes: full on, then full off.
    bus.level_in = 4'd15;
    wait_level(15);
    cnt = 0;
    for (int k = 0; k < 3 * int'(PERIOD); k++) begin
      cycle();
      if (!bus.pwm_out) cnt++;
    end
    check("lvl15_low_clks", 32'(cnt), 32'd0);
    bus.level_in = 4'd0;
    wait_level(0);
    cnt = 0;
    for (int k = 0; k < 3 * int'(PERIOD); k++) begin
      cycle();
      if (bus.pwm_out) cnt++;
    end
    check("lvl0_high_clks", 32'(cnt), 32'd0);

    // Ramp timing from a fresh enable: 0 -> 3.
    bus.enable = 1'b0;
    cycle();
    bus.enable = 1'b1;
    bus.level_in = 4'd3;
    prev = 0;
    busy_fall = -1;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (int'(bus.level_cur) != prev) chg.push_back(k);
      if (!bus.busy && busy_fall < 0) busy_fall = k;
      prev = int'(bus.level_cur);
    end
`ifdef LED_PWM_FADER_FADE_EN
    check("ramp_steps", 32'(chg.size()), 32'd3);
    if (chg.size() == 3) begin
      check("ramp_step1", 32'(chg[0]), 32'd59);
      check("ramp_step2", 32'(chg[1]), 32'd119);
      check("ramp_step3", 32'(chg[2]), 32'd179);
    end
    check("busy_fall", 32'(busy_fall), 32'd179);
`else
    check("jump_steps", 32'(chg.size()), 32'd1);
    if (chg.size() == 1) check("jump_edge", 32'(chg[0]), 32'd29);
    check("busy_fall", 32'(busy_fall), 32'd29);
`endif

    // Mid-period target changes: only the value at the boundary counts.
    bus.level_in = 4'd4;
    wait_level(4);
    wait_slot(7);
    bus.level_in = 4'd9;
    wait_slot(10);
    bus.level_in = 4'd2;
    cnt = 0;
    while (!bus.period_start && cnt < int'(PERIOD) + 2) begin
      cycle();
      cnt++;
    end
    check("mid_boundary_seen", 32'(bus.period_start), 32'd1);
`ifndef LED_PWM_FADER_FADE_EN
    check("mid_level_after", 32'(bus.level_cur), 32'd2);
`endif
    for (int k = 0; k < int'(PERIOD); k++) cycle();

    // Enable drop at slot 8, then restart from slot 0.
    wait_slot(8);
    lvl = int'(bus.level_cur);
    bus.enable = 1'b0;
    cycle();
    check("dis_pwm", 32'(bus.pwm_out), 32'd0);
    check("dis_level_kept", 32'(bus.level_cur), 32'(lvl));
    repeat (4) cycle();
    bus.enable = 1'b1;
    cnt = 0;
    do begin
      cycle();
      cnt++;
    end while (!bus.period_start && cnt < 2 * int'(PERIOD));
    check("reenable_first_ps", 32'(cnt), 32'(PERIOD));

    // Asynchronous reset in the middle of a ramp.
    bus.level_in = 4'd15;
    repeat (100) cycle();
    check("ramp_underway", (bus.level_cur != 4'd0) ? 32'd1 : 32'd0, 32'd1);
    reset_n = 1'b0;
    #2;
    check("arst_level", 32'(bus.level_cur), 32'd0);
    check("arst_pwm", 32'(bus.pwm_out), 32'd0);
    check("arst_ps", 32'(bus.period_start), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized targets and enable toggles against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) bus.level_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) bus.enable = ~bus.enable;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
